// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory port arbiter.
// Holds the one-hot FSM encodings, grant-side constants and the request payload.
package mem_arb_pkg;

    localparam logic [5:0] S_IDLE      = 6'b000001;
    localparam logic [5:0] S_I_REQ     = 6'b000010;
    localparam logic [5:0] S_I_RESP    = 6'b000100;
    localparam logic [5:0] S_D_RD_REQ  = 6'b001000;
    localparam logic [5:0] S_D_RD_RESP = 6'b010000;
    localparam logic [5:0] S_D_WR_REQ  = 6'b100000;

    localparam logic GNT_INST = 1'b0;
    localparam logic GNT_DATA = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around the arbiter.
// slave: the arbiter's view; master: the view of the cores and memory around it.
interface mem_port_arbiter_if;

    logic        inst_req_valid;
    logic [31:0] inst_pc;
    logic        inst_req_ack;
    logic [31:0] inst_rdata;
    logic        inst_valid;
    logic        inst_ack;

    logic [31:0] d_addr;
    logic        d_memread;
    logic        d_memwrite;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_req_ack;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_rack;

    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_addr;
    logic        m_wen;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rready;

    modport slave (
        input  inst_req_valid, inst_pc, inst_ack,
        input  d_addr, d_memread, d_memwrite, d_wdata, d_wstrb, d_rack,
        input  m_req_ready, m_rdata, m_rvalid,
        output inst_req_ack, inst_rdata, inst_valid,
        output d_req_ack, d_rdata, d_rvalid,
        output m_req_valid, m_addr, m_wen, m_wdata, m_wstrb, m_rready
    );

    modport master (
        output inst_req_valid, inst_pc, inst_ack,
        output d_addr, d_memread, d_memwrite, d_wdata, d_wstrb, d_rack,
        output m_req_ready, m_rdata, m_rvalid,
        input  inst_req_ack, inst_rdata, inst_valid,
        input  d_req_ack, d_rdata, d_rvalid,
        input  m_req_valid, m_addr, m_wen, m_wdata, m_wstrb, m_rready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin (RR_EN=1) or fixed data-first (RR_EN=0).
// Ports: clk, rst_n, i_req_inst/i_req_data requests, i_take commits o_gnt.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_inst,
    input  logic i_req_data,
    input  logic i_take,
    output logic o_gnt
);

    logic r_last;

    // On a tie the side that did not win last time goes next.
    always_comb begin
        o_gnt = GNT_INST;
        if (i_req_data && i_req_inst) begin
            if (RR_EN && (r_last == GNT_DATA))
                o_gnt = GNT_INST;
            else
                o_gnt = GNT_DATA;
        end else if (i_req_data) begin
            o_gnt = GNT_DATA;
        end
    end

    // Resetting to inst lets data win the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= GNT_INST;
        else if (i_take)
            r_last <= o_gnt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data, one transaction at a time.
// Ports: clk, rst (async, active-low), bus (fetch, data and memory channels).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    logic [5:0] r_state;
    logic [5:0] w_next;
    mem_req_t   r_req;

    logic w_i_req;
    logic w_d_req;
    logic w_take;
    logic w_gnt;
    logic w_rready;

    logic w_idle;
    logic w_i_rq;
    logic w_i_rs;
    logic w_d_rd;
    logic w_d_rs;
    logic w_d_wr;

    assign w_idle = (r_state == S_IDLE);
    assign w_i_rq = (r_state == S_I_REQ);
    assign w_i_rs = (r_state == S_I_RESP);
    assign w_d_rd = (r_state == S_D_RD_REQ);
    assign w_d_rs = (r_state == S_D_RD_RESP);
    assign w_d_wr = (r_state == S_D_WR_REQ);

    assign w_i_req = bus.inst_req_valid;
    assign w_d_req = bus.d_memread | bus.d_memwrite;
    assign w_take  = w_idle & (w_i_req | w_d_req);

    rr_arb2 #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst),
        .i_req_inst (w_i_req),
        .i_req_data (w_d_req),
        .i_take     (w_take),
        .o_gnt      (w_gnt)
    );

    assign w_rready = (w_i_rs & bus.inst_ack) | (w_d_rs & bus.d_rack);

    always_comb begin
        w_next = r_state;
        unique case (1'b1)
            w_idle: begin
                if (w_take) begin
                    // A read+write collision is treated as a write.
                    if (w_gnt == GNT_DATA)
                        w_next = bus.d_memwrite ? S_D_WR_REQ : S_D_RD_REQ;
                    else
                        w_next = S_I_REQ;
                end
            end
            w_i_rq: if (bus.m_req_ready) w_next = S_I_RESP;
            w_d_rd: if (bus.m_req_ready) w_next = S_D_RD_RESP;
            w_d_wr: if (bus.m_req_ready) w_next = S_IDLE;
            w_i_rs, w_d_rs: begin
                if (bus.m_rvalid && w_rready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Payload is latched at grant so it stays stable even if the requester drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_req   <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                if (w_gnt == GNT_DATA) begin
                    r_req.addr  <= bus.d_addr;
                    r_req.wdata <= bus.d_memwrite ? bus.d_wdata : '0;
                    r_req.wstrb <= bus.d_memwrite ? bus.d_wstrb : '0;
                end else begin
                    r_req.addr  <= bus.inst_pc;
                    r_req.wdata <= '0;
                    r_req.wstrb <= '0;
                end
            end
        end
    end

    assign bus.m_req_valid  = w_i_rq | w_d_rd | w_d_wr;
    assign bus.m_addr       = r_req.addr;
    assign bus.m_wen        = w_d_wr;
    assign bus.m_wdata      = r_req.wdata;
    assign bus.m_wstrb      = w_d_wr ? r_req.wstrb : 4'b0000;

    assign bus.inst_req_ack = w_i_rq & bus.m_req_ready;
    assign bus.d_req_ack    = (w_d_rd | w_d_wr) & bus.m_req_ready;

    assign bus.inst_valid   = w_i_rs & bus.m_rvalid;
    assign bus.d_rvalid     = w_d_rs & bus.m_rvalid;
    assign bus.m_rready     = w_rready;

    assign bus.inst_rdata   = bus.m_rdata;
    assign bus.d_rdata      = bus.m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (round-robin and fixed-priority builds).
// Expected requests/responses are queued at stimulus time and retired by a monitor.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        side;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    mem_port_arbiter_if fp();

    mem_port_arbiter #(.RR_EN(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk (clk),
        .rst (rst),
        .bus (fp)
    );

    req_t q_req[$];
    rsp_t q_rsp[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_rd(input logic side, input logic [31:0] a);
        q_req.push_back('{addr: a, wen: 1'b0, wdata: '0, wstrb: '0});
        q_rsp.push_back('{side: side, data: mem_word(a)});
    endtask

    task automatic idle_bus();
        bus.inst_req_valid = 0; bus.inst_pc = 0; bus.inst_ack = 0;
        bus.d_addr = 0; bus.d_memread = 0; bus.d_memwrite = 0;
        bus.d_wdata = 0; bus.d_wstrb = 0; bus.d_rack = 0;
        bus.m_req_ready = 0; bus.m_rvalid = 0;
    endtask

    task automatic idle_fp();
        fp.inst_req_valid = 0; fp.inst_pc = 0; fp.inst_ack = 0;
        fp.d_addr = 0; fp.d_memread = 0; fp.d_memwrite = 0;
        fp.d_wdata = 0; fp.d_wstrb = 0; fp.d_rack = 0;
        fp.m_req_ready = 0; fp.m_rvalid = 0; fp.m_rdata = 0;
    endtask

    // Monitor and memory model, sampled just before each rising edge.
    always begin
        req_t r;
        rsp_t s;
        @(negedge clk);
        #4;
        if (rst) begin
            if (bus.m_req_valid && bus.m_req_ready) begin
                check("sb_req_pending", 32'(q_req.size() != 0), 1);
                if (q_req.size() != 0) begin
                    r = q_req.pop_front();
                    check("sb_req_addr", bus.m_addr, r.addr);
                    check("sb_req_wen", 32'(bus.m_wen), 32'(r.wen));
                    if (r.wen) begin
                        check("sb_req_wdata", bus.m_wdata, r.wdata);
                        check("sb_req_wstrb", 32'(bus.m_wstrb), 32'(r.wstrb));
                    end
                end
                bus.m_rdata = mem_word(bus.m_addr);
            end
            if ((bus.inst_valid && bus.inst_ack) || (bus.d_rvalid && bus.d_rack)) begin
                check("sb_rsp_pending", 32'(q_rsp.size() != 0), 1);
                if (q_rsp.size() != 0) begin
                    s = q_rsp.pop_front();
                    check("sb_rsp_side", 32'(bus.d_rvalid), 32'(s.side));
                    check("sb_rsp_data",
                          bus.d_rvalid ? bus.d_rdata : bus.inst_rdata, s.data);
                end
            end
        end
    end

    initial begin
        int n_ack;
        idle_bus();
        idle_fp();
        bus.m_rdata = 0;
        rst = 0;

        // Reset with busy-looking inputs: all gated outputs must be 0.
        bus.inst_req_valid = 1; bus.d_memwrite = 1; bus.m_req_ready = 1;
        bus.m_rvalid = 1; bus.inst_ack = 1; bus.d_rack = 1;
        bus.d_wdata = 32'hFFFF_FFFF; bus.d_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_mreqv", 32'(bus.m_req_valid), 0);
        check("rst_wen", 32'(bus.m_wen), 0);
        check("rst_wstrb", 32'(bus.m_wstrb), 0);
        check("rst_rready", 32'(bus.m_rready), 0);
        check("rst_iack", 32'(bus.inst_req_ack), 0);
        check("rst_dack", 32'(bus.d_req_ack), 0);
        check("rst_ivalid", 32'(bus.inst_valid), 0);
        check("rst_dvalid", 32'(bus.d_rvalid), 0);
        check("rst_addr", bus.m_addr, 0);
        check("rst_wdata", bus.m_wdata, 0);
        idle_bus();
        rst = 1;

        // Single fetch from 0x100.
        @(negedge clk);
        bus.inst_req_valid = 1; bus.inst_pc = 32'h100;
        bus.m_req_ready = 1; bus.inst_ack = 1;
        push_rd(GNT_INST, 32'h100);
        @(negedge clk);
        check("t1_mreqv", 32'(bus.m_req_valid), 1);
        check("t1_addr", bus.m_addr, 32'h100);
        check("t1_wen", 32'(bus.m_wen), 0);
        check("t1_wstrb", 32'(bus.m_wstrb), 0);
        check("t1_iack", 32'(bus.inst_req_ack), 1);
        check("t1_dack", 32'(bus.d_req_ack), 0);
        bus.inst_req_valid = 0;
        bus.m_rvalid = 1;
        #1;
        check("t1_gate_req", 32'(bus.inst_valid), 0);
        @(negedge clk);
        check("t1_ivalid", 32'(bus.inst_valid), 1);
        check("t1_irdata", bus.inst_rdata, 32'h13);
        check("t1_drdata", bus.d_rdata, 32'h13);
        check("t1_rready", 32'(bus.m_rready), 1);
        check("t1_dvalid", 32'(bus.d_rvalid), 0);
        @(negedge clk);
        check("t1_idle_mreqv", 32'(bus.m_req_valid), 0);
        check("t1_idle_ivalid", 32'(bus.inst_valid), 0);
        check("t1_idle_rready", 32'(bus.m_rready), 0);
        idle_bus();

        // Round-robin: tie from reset goes D, I, D, I.
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        bus.inst_req_valid = 1; bus.inst_pc = 32'h200;
        bus.d_memread = 1; bus.d_addr = 32'h1000;
        bus.m_req_ready = 1; bus.m_rvalid = 1;
        bus.inst_ack = 1; bus.d_rack = 1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_rd(GNT_DATA, 32'h1000);
            else            push_rd(GNT_INST, 32'h200);
        end
        repeat (12) @(negedge clk);
        idle_bus();
        repeat (2) @(negedge clk);
        check("t2_req_drained", q_req.size(), 0);
        check("t2_rsp_drained", q_rsp.size(), 0);

        // Fixed priority: data always wins, fetch never acked.
        fp.inst_req_valid = 1; fp.inst_pc = 32'h200;
        fp.d_memread = 1; fp.d_addr = 32'h1000;
        fp.m_req_ready = 1; fp.m_rvalid = 1;
        fp.inst_ack = 1; fp.d_rack = 1;
        n_ack = 0;
        repeat (12) begin
            @(negedge clk);
            #4;
            n_ack += int'(fp.d_req_ack);
            check("t3_iack", 32'(fp.inst_req_ack), 0);
            check("t3_ivalid", 32'(fp.inst_valid), 0);
        end
        check("t3_dgrants", n_ack, 4);
        idle_fp();

        // Store with backpressure; read+write collision counts as write.
        @(negedge clk);
        bus.d_memwrite = 1; bus.d_memread = 1;
        bus.d_addr = 32'h2004; bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b1100;
        bus.m_req_ready = 0; bus.m_rvalid = 1; bus.d_rack = 1;
        q_req.push_back('{addr: 32'h2004, wen: 1'b1,
                          wdata: 32'hDEAD_BEEF, wstrb: 4'b1100});
        @(negedge clk);
        bus.d_memwrite = 0; bus.d_memread = 0;
        bus.d_addr = 32'hFFFF_FFF0; bus.d_wdata = 0; bus.d_wstrb = 0;
        n_ack = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_mreqv", 32'(bus.m_req_valid), 1);
            check("t4_wen", 32'(bus.m_wen), 1);
            check("t4_addr", bus.m_addr, 32'h2004);
            check("t4_wdata", bus.m_wdata, 32'hDEAD_BEEF);
            check("t4_wstrb", 32'(bus.m_wstrb), 32'hC);
            n_ack += int'(bus.d_req_ack);
            @(negedge clk);
        end
        bus.m_req_ready = 1;
        #4;
        n_ack += int'(bus.d_req_ack);
        @(negedge clk);
        n_ack += int'(bus.d_req_ack);
        check("t4_dack_once", n_ack, 1);
        check("t4_idle", 32'(bus.m_req_valid), 0);
        check("t4_no_resp", 32'(bus.d_rvalid), 0);
        @(negedge clk);
        check("t4_no_resp2", 32'(bus.d_rvalid), 0);
        idle_bus();

        // Reset in I_RESP, then restart from IDLE.
        @(negedge clk);
        bus.inst_req_valid = 1; bus.inst_pc = 32'h300;
        bus.m_req_ready = 1; bus.m_rvalid = 1; bus.inst_ack = 0;
        q_req.push_back('{addr: 32'h300, wen: 1'b0, wdata: '0, wstrb: '0});
        @(negedge clk);
        bus.inst_req_valid = 0;
        @(negedge clk);
        check("t5_ivalid", 32'(bus.inst_valid), 1);
        #2;
        bus.inst_ack = 1;
        rst = 0;
        #1;
        check("t5_rst_ivalid", 32'(bus.inst_valid), 0);
        check("t5_rst_rready", 32'(bus.m_rready), 0);
        check("t5_rst_mreqv", 32'(bus.m_req_valid), 0);
        check("t5_rst_addr", bus.m_addr, 0);
        check("t5_rst_wdata", bus.m_wdata, 0);
        check("t5_rst_wstrb", 32'(bus.m_wstrb), 0);
        check("t5_rst_wen", 32'(bus.m_wen), 0);
        check("t5_rst_iack", 32'(bus.inst_req_ack), 0);
        check("t5_rst_dvalid", 32'(bus.d_rvalid), 0);
        @(negedge clk);
        rst = 1;
        bus.inst_req_valid = 1; bus.inst_pc = 32'h400;
        bus.d_memread = 1; bus.d_addr = 32'h1000; bus.d_rack = 1;
        push_rd(GNT_DATA, 32'h1000);
        push_rd(GNT_INST, 32'h400);
        @(negedge clk);
        check("t5_first_v", 32'(bus.m_req_valid), 1);
        check("t5_first_addr", bus.m_addr, 32'h1000);
        repeat (5) @(negedge clk);
        idle_bus();
        repeat (2) @(negedge clk);
        check("t5_req_drained", q_req.size(), 0);
        check("t5_rsp_drained", q_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, where 1 selects round-robin arbitration and 0 selects fixed data-over-instruction priority.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port inst_req_valid, input, 1 bit: the fetch side requests a read.
REQ-005 The block SHALL have port inst_pc, input, 32 bits: the fetch address.
REQ-006 The block SHALL have port inst_req_ack, output, 1 bit: fetch request accepted.
REQ-007 The block SHALL have port inst_rdata, output, 32 bits: the fetched instruction.
REQ-008 The block SHALL have port inst_valid, output, 1 bit: inst_rdata is valid.
REQ-009 The block SHALL have port inst_ack, input, 1 bit: the fetch side accepts inst_rdata.
REQ-010 The block SHALL have port d_addr, input, 32 bits: the word-aligned data address.
REQ-011 The block SHALL have port d_memread, input, 1 bit: data read request.
REQ-012 The block SHALL have port d_memwrite, input, 1 bit: data write request.
REQ-013 The block SHALL have port d_wdata, input, 32 bits: the write data.
REQ-014 The block SHALL have port d_wstrb, input, 4 bits: the byte write strobes.
REQ-015 The block SHALL have port d_req_ack, output, 1 bit: data request accepted.
REQ-016 The block SHALL have port d_rdata, output, 32 bits: the load data.
REQ-017 The block SHALL have port d_rvalid, output, 1 bit: d_rdata is valid.
REQ-018 The block SHALL have port d_rack, input, 1 bit: the data side accepts d_rdata.
REQ-019 The block SHALL have port m_req_valid, output, 1 bit: request to the shared memory.
REQ-020 The block SHALL have port m_req_ready, input, 1 bit: the memory accepts the request.
REQ-021 The block SHALL have ports m_addr (output, 32 bits), m_wen (output, 1 bit), m_wdata (output, 32 bits) and m_wstrb (output, 4 bits), carrying the request payload.
REQ-022 The block SHALL have ports m_rdata (input, 32 bits), m_rvalid (input, 1 bit) and m_rready (output, 1 bit), forming the memory read response channel.

Function
REQ-023 The FSM SHALL have the states IDLE, I_REQ, I_RESP, D_RD_REQ, D_RD_RESP and D_WR_REQ, one-hot encoded, with exactly one transaction outstanding at a time.
REQ-024 In IDLE, a data request (d_memread or d_memwrite) and inst_req_valid SHALL be sampled, and the winner SHALL be registered; the chosen REQ state is entered next cycle, giving 1 cycle of arbitration latency.
REQ-025 When RR_EN=1 and both sides request, the side not granted last SHALL win; the last-grant register resets to "inst" so that data wins the first tie; when RR_EN=0, data SHALL always win.
REQ-026 If d_memread and d_memwrite are both 1, the block SHALL treat the request as a write.
REQ-027 In a REQ state, m_req_valid=1 and the payload SHALL be driven from the granted side: instruction gives m_wen=0 and m_wstrb=0; a data read gives m_wen=0; a data write gives m_wen=1.
REQ-028 inst_req_ack and d_req_ack SHALL equal (m_req_valid & m_req_ready) for the granted side only; the REQ state SHALL hold while m_req_ready=0, with the payload stable.
REQ-029 On handshake, I_REQ SHALL go to I_RESP, D_RD_REQ to D_RD_RESP, and D_WR_REQ to IDLE, because writes have no response phase.
REQ-030 In a RESP state, m_rvalid and m_rdata SHALL pass combinationally to the granted side's valid/rdata, and m_rready SHALL equal that side's ack; on (m_rvalid & m_rready) the FSM SHALL return to IDLE.
REQ-031 Outside the granted RESP state, inst_valid, d_rvalid and m_rready SHALL be 0, and m_rvalid SHALL be ignored.
REQ-032 inst_rdata and d_rdata SHALL equal m_rdata at all times; only the valids are gated.
REQ-033 A request that deasserts before its ack is out of protocol, and the block SHALL complete the granted transaction regardless.

Reset
REQ-034 While rst=0, the FSM SHALL be IDLE and last-grant SHALL be "inst"; m_req_valid, m_wen, m_wstrb, m_rready, inst_req_ack, d_req_ack, inst_valid and d_rvalid SHALL be 0, and m_addr and m_wdata SHALL be 0.
REQ-035 When reset asserts mid-transaction, the transaction SHALL be abandoned with no replay; after release, arbitration restarts from IDLE on the first rising edge.

Structure
REQ-036 The state encodings and the grant-side constants SHALL reside in the shared package mem_arb_pkg.
REQ-037 The arbitration decision SHALL be implemented in the sub-module rr_arb2, a 2-requester round-robin/fixed-priority picker with a last-grant register; everything else is flat.

Verification
REQ-038 The bench SHALL cover: inst_req_valid alone with inst_pc=0x100 and m_req_ready=1 -> m_req_valid one cycle after the request, m_addr=0x100, m_wen=0, then m_rdata=0x00000013 delivered with inst_valid=1, back to IDLE.
REQ-039 The bench SHALL cover: simultaneous fetch (0x200) and load (0x1000) from reset with RR_EN=1 -> the data read is granted first, then the fetch; with both held, grants alternate D, I, D, I.
REQ-040 The bench SHALL cover: RR_EN=0 with both requesting continuously -> only data is granted, and inst_req_ack stays 0.
REQ-041 The bench SHALL cover: a store to 0x2004 with d_wdata=0xDEADBEEF, d_wstrb=4'b1100 and m_req_ready held 0 for 3 cycles -> the payload is stable for 3 cycles, d_req_ack pulses once, and there is no response phase.
REQ-042 The bench SHALL cover: rst=0 asserted in I_RESP while m_rvalid=1 -> all outputs are 0 asynchronously, and the next request after release is arbitrated from IDLE.
